// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: PC, next-PC select, imem req/ack, one-entry buffer
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc_4,
  output logic        ir_valid
);

  typedef enum logic {FETCH, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] target;
  logic        pending;

  logic [31:0] redirect_aligned;
  logic [31:0] pc_next4;
  logic        take;
  logic        in_flight;

  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign pc_next4         = pc + 32'd4;
  assign take             = imem_req & imem_ack;
  assign in_flight        = imem_req & ~imem_ack;
  assign imem_addr        = pc & 32'hFFFF_FFFC;

  // An unanswered request keeps req high regardless of stall, so the memory sees a stable handshake.
  always_comb begin
    imem_req = 1'b0;
    if (!rst) begin
      if (state == DISCARD || pending)
        imem_req = 1'b1;
      else
        imem_req = ~ir_valid | ~stall;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      target   <= 32'h0;
      pending  <= 1'b0;
      ir       <= 32'h0;
      pc_4     <= 32'h0;
      ir_valid <= 1'b0;
    end else begin
      pending <= in_flight;
      case (state)
        FETCH: begin
          if (redirect) begin
            ir       <= 32'h0;
            pc_4     <= 32'h0;
            ir_valid <= 1'b0;
            if (in_flight) begin
              target <= redirect_aligned;
              state  <= DISCARD;
            end else begin
              pc <= redirect_aligned;
            end
          end else if (take) begin
            ir       <= imem_rdata;
            pc_4     <= pc_next4;
            pc       <= pc_next4;
            ir_valid <= 1'b1;
          end else if (ir_valid && !stall) begin
            ir       <= 32'h0;
            pc_4     <= 32'h0;
            ir_valid <= 1'b0;
          end
        end
        DISCARD: begin
          // A redirect arriving together with the ack still wins over the older target.
          if (redirect)
            target <= redirect_aligned;
          if (take) begin
            pc    <= redirect ? redirect_aligned : target;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
